// File: rtl/refresh_pkg.sv
// Shared types and defaults for the gain-cell refresh path.
// The interval counter and the row sequencer both read these defaults.
package refresh_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } ref_state_t;

  localparam int REF_ROWS     = 64;
  localparam int REF_READ_LAT = 2;
  localparam int REF_DATA_W   = 32;

endpackage

// File: rtl/refresh_row_sequencer.sv
// Sweeps every gain-cell row once per refresh tick: read the row,
// then write the same data back, arbitrating per row via req/gnt.
module refresh_row_sequencer
  import refresh_pkg::*;
#(
  parameter int ROWS     = REF_ROWS,
  parameter int ADDR_W   = $clog2(ROWS),
  parameter int DATA_W   = REF_DATA_W,
  parameter int READ_LAT = REF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_tick,
  input  logic              disable_ref,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              missed_tick
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(READ_LAT - 1);

  ref_state_t state_q, state_d;

  logic [ADDR_W-1:0] row_q, row_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic missed_q, missed_d;
  logic req_q, req_d;
  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    wait_d   = wait_q;
    data_d   = data_q;
    missed_d = missed_q;

    // A tick arriving mid-sweep is dropped, never queued.
    if (refresh_tick && state_q != IDLE)
      missed_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (refresh_tick && !disable_ref)
          state_d = REQ;
      end
      REQ: begin
        if (disable_ref) begin
          state_d = IDLE;
          row_d   = '0;
        end else if (mem_gnt) begin
          state_d = READ;
        end
      end
      READ: begin
        wait_d  = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          data_d  = mem_rd_data;
          state_d = WRITE;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      WRITE: begin
        // An abort only takes effect once the row is written back.
        if (disable_ref) begin
          state_d = IDLE;
          row_d   = '0;
        end else if (row_q == LAST_ROW) begin
          state_d = DONE;
          row_d   = '0;
        end else begin
          state_d = REQ;
          row_d   = row_q + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request drops on the first REQ cycle of each row so other
  // masters get a chance to win arbitration between rows.
  always_comb begin
    req_d  = (state_d == REQ && state_q == REQ) ||
             (state_d == READ) ||
             (state_d == WAIT) ||
             (state_d == WRITE);
    rd_d   = (state_d == READ);
    wr_d   = (state_d == WRITE);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      missed_q <= 1'b0;
      req_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      missed_q <= missed_d;
      req_q    <= req_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = row_q;
  assign mem_rd_en   = rd_q;
  assign mem_wr_en   = wr_q;
  assign mem_wr_data = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign missed_tick = missed_q;

endmodule

// File: tb/tb_refresh_row_sequencer.sv
// Directed bench for refresh_row_sequencer with ROWS=4, READ_LAT=2.
// A small memory model returns 'hA0+row two cycles after each read.
module tb_refresh_row_sequencer;

  localparam int ROWS = 4;
  localparam int RL   = 2;
  localparam int DW   = 32;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          refresh_tick = 1'b0;
  logic          disable_ref = 1'b0;
  logic          mem_gnt = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic          busy;
  logic          done;
  logic          missed_tick;

  refresh_row_sequencer #(
    .ROWS(ROWS), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .refresh_tick(refresh_tick), .disable_ref(disable_ref),
    .mem_gnt(mem_gnt), .mem_rd_data(mem_rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done),
    .missed_tick(missed_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc_n = 0;

  int rd_q[$];
  int wr_a[$];
  int wr_d[$];
  int start_c, done_c, done_n, busy_n, req_n;
  logic req_at_start;
  logic prev_busy = 1'b0;

  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  int   a0 = 0, a1 = 0, a2 = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rd_q.delete();
    wr_a.delete();
    wr_d.delete();
    start_c = -1;
    done_c = -1;
    done_n = 0;
    busy_n = 0;
    req_n = 0;
    req_at_start = 1'bx;
  endtask

  // One clock: observe outputs just after the edge, then drive the
  // read data for the current cycle from the 2-deep read history.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    v2 = v1; a2 = a1;
    v1 = v0; a1 = a0;
    v0 = mem_rd_en; a0 = int'(mem_addr);
    mem_rd_data = v2 ? 32'hA0 + a2 : 32'hDEAD_BEEF;
    if (mem_rd_en) rd_q.push_back(int'(mem_addr));
    if (mem_wr_en) begin
      wr_a.push_back(int'(mem_addr));
      wr_d.push_back(int'(mem_wr_data));
    end
    if (busy) busy_n++;
    if (mem_req) req_n++;
    if (busy && !prev_busy && start_c < 0) begin
      start_c = cyc_n;
      req_at_start = mem_req;
    end
    if (done) begin
      done_n++;
      done_c = cyc_n;
    end
    prev_busy = busy;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_tick();
    refresh_tick = 1'b1;
    cyc();
    refresh_tick = 1'b0;
  endtask

  task automatic wait_rd(int addr);
    int k = 0;
    while (!(mem_rd_en && int'(mem_addr) == addr) && k < 100) begin
      cyc();
      k++;
    end
    chk("wait_rd", 32'(k < 100), 1);
  endtask

  task automatic wait_wr(int addr);
    int k = 0;
    while (!(mem_wr_en && int'(mem_addr) == addr) && k < 100) begin
      cyc();
      k++;
    end
    chk("wait_wr", 32'(k < 100), 1);
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd_en, 0);
    chk("rst_wr", mem_wr_en, 0);
    chk("rst_wdata", mem_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_missed", missed_tick, 0);
    rst = 1'b0;
    run(2);

    // Basic sweep with grant tied high.
    mem_gnt = 1'b1;
    clr();
    pulse_tick();
    run(30);
    chk("t1_nrd", rd_q.size(), 4);
    chk("t1_nwr", wr_a.size(), 4);
    for (int i = 0; i < ROWS; i++) begin
      chk("t1_rd_addr", rd_q[i], i);
      chk("t1_wr_addr", wr_a[i], i);
      chk("t1_wr_data", wr_d[i], 32'hA0 + i);
    end
    chk("t1_lat", done_c - start_c, 20);
    chk("t1_done_n", done_n, 1);
    chk("t1_busy_n", busy_n, 21);
    chk("t1_req_entry", req_at_start, 0);
    chk("t1_missed", missed_tick, 0);
    chk("t1_idle", busy, 0);

    // Grant withheld for 5 extra cycles on row 2.
    clr();
    pulse_tick();
    wait_wr(1);
    mem_gnt = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      chk("t2_hold", {mem_addr, mem_rd_en, mem_wr_en}, {2'd2, 2'b00});
      chk("t2_req", mem_req, (j >= 2) ? 1 : 0);
    end
    mem_gnt = 1'b1;
    run(40);
    chk("t2_lat", done_c - start_c, 25);
    chk("t2_nrd", rd_q.size(), 4);
    chk("t2_done_n", done_n, 1);

    // Tick while disabled in IDLE.
    disable_ref = 1'b1;
    clr();
    pulse_tick();
    run(5);
    chk("t6_busy_n", busy_n, 0);
    chk("t6_req_n", req_n, 0);
    chk("t6_missed", missed_tick, 0);
    disable_ref = 1'b0;

    // Abort during WAIT of row 1.
    clr();
    pulse_tick();
    wait_rd(1);
    cyc();
    disable_ref = 1'b1;
    run(10);
    chk("t4_nwr", wr_a.size(), 2);
    chk("t4_wr_addr", wr_a[1], 1);
    chk("t4_wr_data", wr_d[1], 32'hA1);
    chk("t4_nrd", rd_q.size(), 2);
    chk("t4_done_n", done_n, 0);
    chk("t4_busy", busy, 0);
    disable_ref = 1'b0;
    clr();
    pulse_tick();
    run(30);
    chk("t4b_first", rd_q[0], 0);
    chk("t4b_nrd", rd_q.size(), 4);
    chk("t4b_done_n", done_n, 1);

    // Second tick mid-sweep.
    clr();
    pulse_tick();
    wait_rd(1);
    refresh_tick = 1'b1;
    cyc();
    refresh_tick = 1'b0;
    chk("t3_missed_set", missed_tick, 1);
    run(40);
    chk("t3_lat", done_c - start_c, 20);
    chk("t3_done_n", done_n, 1);
    chk("t3_busy_n", busy_n, 21);
    chk("t3_nrd", rd_q.size(), 4);
    chk("t3_missed_sticky", missed_tick, 1);

    // Asynchronous reset during WAIT of row 2.
    clr();
    pulse_tick();
    wait_rd(2);
    cyc();
    rst = 1'b1;
    #1;
    chk("t5_req", mem_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_rdwr", {mem_rd_en, mem_wr_en}, 0);
    chk("t5_wdata", mem_wr_data, 0);
    chk("t5_done", done, 0);
    chk("t5_missed", missed_tick, 0);
    cyc();
    rst = 1'b0;
    cyc();
    clr();
    pulse_tick();
    run(30);
    chk("t5b_first", rd_q[0], 0);
    chk("t5b_nrd", rd_q.size(), 4);
    chk("t5b_done_n", done_n, 1);
    chk("t5b_lat", done_c - start_c, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
